tc_timer: RTL and testbench
===========================

TC_TIMER -- requirements
Module: tc_timer

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-003 The block SHALL have the port `addr`, input, 2 bits: word offset of the memory-stage address (address bits 3:2); 00=CTRL, 01=PRESET, 10=COUNT, 11=unused.
REQ-004 The block SHALL have the port `we`, input, 1 bit: write strobe from the memory stage, already decoded by the bridge for the timer address range.
REQ-005 The block SHALL have the port `din`, input, 32 bits: store data from the memory stage.
REQ-006 The block SHALL have the port `dout`, output, 32 bits: combinational read data for `addr`.
REQ-007 The block SHALL have the port `irq`, output, 1 bit: interrupt request to the CP0/exception logic.

Function
REQ-008 CTRL layout SHALL be: [0] Enable, [2:1] Mode (00 one-shot, 01 auto-reload, 10/11 treated as 00), [3] IM (interrupt mask); all other bits SHALL read 0 except as REQ-025 allows.
REQ-009 A write (`we`=1) SHALL update the register selected by `addr` on the rising edge; a write to COUNT or to 11 SHALL be ignored.
REQ-010 `dout` SHALL return CTRL, PRESET or COUNT for `addr` 00/01/10, and 0 for 11.
REQ-011 The FSM SHALL have the states IDLE, LOAD, CNT and INT.
REQ-012 IDLE SHALL go to LOAD on the edge where Enable=1.
REQ-013 LOAD SHALL set COUNT to PRESET and go to CNT on the next edge.
REQ-014 CNT with Enable=1 SHALL decrement COUNT by 1 per edge while COUNT≠0, and SHALL go to INT on the edge where COUNT==0.
REQ-015 CNT with Enable=0 SHALL go to IDLE on the next edge, with COUNT held.
REQ-016 In INT with Mode 00, the block SHALL clear Enable, set irq_flag, and go to IDLE on the next edge.
REQ-017 In INT with Mode 01, the block SHALL set irq_flag for exactly one cycle and go to LOAD (reload) on the next edge.
REQ-018 `irq` SHALL equal IM AND irq_flag.
REQ-019 A Mode 00 irq_flag SHALL remain set until any CTRL write or reset.
REQ-020 Latency: when CTRL is written with Enable=1 at edge t, COUNT SHALL equal PRESET after edge t+2 and `irq` SHALL rise after edge t+3+PRESET.
REQ-021 With PRESET=0, INT SHALL be reached 3 edges after enable; the auto-reload period SHALL be PRESET+3 cycles.
REQ-022 A PRESET write during CNT SHALL affect only the next LOAD and SHALL NOT change COUNT.
REQ-023 When a CTRL write coincides with the INT edge, the written value SHALL win for Enable/Mode/IM, and irq_flag SHALL still be set per Mode.
REQ-024 COUNT SHALL never wrap below 0.

Reset
REQ-025 While `reset`=0 the block SHALL hold CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, prescale counter=0, and `irq`=0.
REQ-026 Reset asserted mid-count SHALL abort the count immediately, and no `irq` SHALL be produced after reset releases.

Configuration
REQ-027 With macro TC_PRESCALE_EN defined, CTRL[11:4] SHALL be a read/write divisor P, and CNT SHALL decrement or zero-test only on a tick occurring every P+1 edges.
REQ-028 With TC_PRESCALE_EN defined, the prescale counter SHALL clear in LOAD and IDLE, and P=0 SHALL behave identically to the non-prescale build.
REQ-029 Without TC_PRESCALE_EN, CTRL[11:4] SHALL read 0, writes to those bits SHALL be ignored, and a tick SHALL occur every edge.

Verification
REQ-030 A bench SHALL cover: PRESET=5, CTRL=0x9 (enable, one-shot, IM) at edge t -> COUNT 5,4,3,2,1,0, `irq`=1 after edge t+8, Enable reads 0, `irq` holds until a CTRL write.
REQ-031 A bench SHALL cover: PRESET=2, CTRL=0xB (auto-reload) -> `irq` one-cycle pulses every 5 cycles, at least 3 periods.
REQ-032 A bench SHALL cover: CTRL=0x1 (IM=0), PRESET=3 -> INT reached, `irq` stays 0, CTRL bit0 clears.
REQ-033 A bench SHALL cover: during CNT at COUNT=4, write CTRL=0 -> IDLE next edge, COUNT stays 4; re-enable -> reload from PRESET.
REQ-034 A bench SHALL cover: reset pulled low mid-CNT at COUNT=7 -> all registers read 0 immediately, `irq`=0, no later interrupt.
REQ-035 A bench SHALL cover (TC_PRESCALE_EN build): P=3, PRESET=2 -> COUNT changes every 4 edges, `irq` after edge t+3+4·2.

Source files
------------

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer with interrupt.
// Registers: CTRL (addr 00), PRESET (addr 01), COUNT (addr 10, read-only).
// The CTRL[11:4] prescale divisor exists only when TC_PRESCALE_EN is defined.
// Without it, those bits read 0 and the counter steps on every clock edge.
module tc_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic        flag_q, flag_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        tick;
  logic [7:0]  div_rd;

  assign ctrl_wr   = we && (addr == 2'b00);
  assign preset_wr = we && (addr == 2'b01);

`ifdef TC_PRESCALE_EN
  logic [7:0] div_q, div_d;
  logic [7:0] ps_q, ps_d;

  // Prescale divisor register and tick counter; the counter only runs while counting.
  always_comb begin
    div_d = div_q;
    ps_d  = 8'd0;
    if (ctrl_wr) begin
      div_d = din[11:4];
    end
    if (state_q == CNT && en_q) begin
      ps_d = (ps_q >= div_q) ? 8'd0 : ps_q + 8'd1;
    end
  end

  // Prescale state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= 8'd0;
      ps_q  <= 8'd0;
    end else begin
      div_q <= div_d;
      ps_q  <= ps_d;
    end
  end

  // First counting edge after LOAD is a tick, then one every P+1 edges.
  assign tick   = (ps_q == 8'd0);
  assign div_rd = div_q;
`else
  assign tick   = 1'b1;
  assign div_rd = 8'd0;
`endif

  // Register writes, next-state logic and count/interrupt-flag updates.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    flag_d   = flag_q;
    preset_d = preset_q;
    count_d  = count_q;

    if (ctrl_wr) begin
      en_d   = din[0];
      mode_d = din[2:1];
      im_d   = din[3];
      flag_d = 1'b0;
    end
    if (preset_wr) begin
      preset_d = din;
    end

    case (state_q)
      IDLE: begin
        if (en_q) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
          end else begin
            // The flag rises on entry so irq is visible while in INT.
            state_d = INT;
            flag_d  = 1'b1;
          end
        end
      end
      INT: begin
        if (mode_q == 2'b01) begin
          flag_d  = 1'b0;
          state_d = LOAD;
        end else begin
          // One-shot: flag is sticky, and a simultaneous CTRL write keeps its Enable.
          flag_d = 1'b1;
          if (!ctrl_wr) en_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Main state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      flag_q   <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      flag_q   <= flag_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  // Combinational register read mux.
  always_comb begin
    dout = 32'd0;
    case (addr)
      2'b00:   dout = {20'd0, div_rd, im_q, mode_q, en_q};
      2'b01:   dout = preset_q;
      2'b10:   dout = count_q;
      default: dout = 32'd0;
    endcase
  end

  assign irq = im_q & flag_q;

endmodule

// File: tb/tb_tc_timer.sv
// Bench for tc_timer: directed scenarios with fixed expectations plus a random
// run compared each cycle against a phase-based behavioural model.
module tb_tc_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  tc_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a timer is waiting, loading, running or firing.
  localparam int PH_WAIT = 0, PH_LOADING = 1, PH_RUN = 2, PH_FIRE = 3;
  int          m_phase, n_phase;
  int          m_elapsed, n_elapsed;
  logic        m_en, n_en, m_im, n_im, m_flag, n_flag;
  logic [1:0]  m_mode, n_mode;
  logic [7:0]  m_p, n_p;
  logic [31:0] m_preset, n_preset, m_count, n_count;

  // Last values read back from the DUT.
  logic [31:0] r_rd [4];
  logic        r_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input int a);
    case (a)
      0:       return {20'd0, m_p, m_im, m_mode, m_en};
      1:       return m_preset;
      2:       return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    m_phase = PH_WAIT; m_elapsed = 0;
    m_en = 0; m_im = 0; m_flag = 0; m_mode = 0; m_p = 0;
    m_preset = 0; m_count = 0;
  endtask

  task automatic model_next(input logic w, input logic [1:0] a, input logic [31:0] d);
    logic cw;
    cw = w && (a == 2'd0);
    n_phase = m_phase; n_elapsed = m_elapsed;
    n_en = m_en; n_im = m_im; n_flag = m_flag; n_mode = m_mode; n_p = m_p;
    n_preset = m_preset; n_count = m_count;
    if (cw) begin
      n_en = d[0]; n_mode = d[2:1]; n_im = d[3]; n_flag = 0;
`ifdef TC_PRESCALE_EN
      n_p = d[11:4];
`else
      n_p = 8'd0;
`endif
    end
    if (w && a == 2'd1) n_preset = d;
    case (m_phase)
      PH_WAIT: if (m_en) n_phase = PH_LOADING;
      PH_LOADING: begin
        n_count = m_preset; n_elapsed = 0; n_phase = PH_RUN;
      end
      PH_RUN: begin
        if (!m_en) n_phase = PH_WAIT;
        else begin
          if (m_elapsed % (int'(m_p) + 1) == 0) begin
            if (m_count > 0) n_count = m_count - 1;
            else begin n_phase = PH_FIRE; n_flag = 1; end
          end
          n_elapsed = m_elapsed + 1;
        end
      end
      default: begin
        if (m_mode == 2'b01) begin
          n_flag = 0; n_phase = PH_LOADING;
        end else begin
          n_flag = 1; n_phase = PH_WAIT;
          if (!cw) n_en = 0;
        end
      end
    endcase
  endtask

  task automatic model_commit();
    m_phase = n_phase; m_elapsed = n_elapsed;
    m_en = n_en; m_im = n_im; m_flag = n_flag; m_mode = n_mode; m_p = n_p;
    m_preset = n_preset; m_count = n_count;
  endtask

  // Read every address and irq, comparing with the model.
  task automatic probe(input string tag);
    for (int i = 0; i < 4; i++) begin
      addr = i[1:0];
      #1;
      r_rd[i] = dout;
      check($sformatf("%s_rd%0d", tag, i), dout, model_rd(i));
    end
    r_irq = irq;
    check($sformatf("%s_irq", tag), {31'd0, irq}, {31'd0, m_im & m_flag});
  endtask

  // One clock edge with the given bus access, then read back.
  task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
    we = w; addr = a; din = d;
    model_next(w, a, d);
    @(posedge clk);
    model_commit();
    #1;
    we = 0; din = 0;
    probe("stp");
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 32'd0);
  endtask

  // Asynchronous reset pulse: everything must read 0 before any clock edge.
  task automatic do_reset();
    reset = 1'b0; we = 1'b0;
    model_clear();
    #1;
    probe("rst");
    check("rst_ctrl", r_rd[0], 32'd0);
    check("rst_cnt", r_rd[2], 32'd0);
    check("rst_irq", {31'd0, r_irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  p_sel;
    int          r;
    reset = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;
    do_reset();

    // One-shot, PRESET=5, IM=1.
    step(1, 2'd1, 32'd5);
    step(1, 2'd0, 32'h9);
    for (int i = 1; i <= 12; i++) begin
      idle();
      if (i >= 2 && i <= 7) check($sformatf("os_cnt%0d", i), r_rd[2], 32'(7 - i));
      check($sformatf("os_irq%0d", i), {31'd0, r_irq}, {31'd0, (i >= 8) ? 1'b1 : 1'b0});
      if (i >= 9) check($sformatf("os_ctrl%0d", i), r_rd[0], 32'h8);
    end
    step(1, 2'd0, 32'h0);
    check("os_irq_clr", {31'd0, r_irq}, 32'd0);

    // Auto-reload, PRESET=2: pulse every 5 edges.
    do_reset();
    step(1, 2'd1, 32'd2);
    step(1, 2'd0, 32'hB);
    for (int i = 1; i <= 20; i++) begin
      idle();
      check($sformatf("ar_irq%0d", i), {31'd0, r_irq},
            {31'd0, (i >= 5 && i % 5 == 0) ? 1'b1 : 1'b0});
    end

    // Masked interrupt, PRESET=3.
    do_reset();
    step(1, 2'd1, 32'd3);
    step(1, 2'd0, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      idle();
      check($sformatf("mk_irq%0d", i), {31'd0, r_irq}, 32'd0);
      check($sformatf("mk_ctrl%0d", i), r_rd[0], (i >= 7) ? 32'd0 : 32'd1);
    end

    // Disable mid-count at COUNT=4, then re-enable.
    do_reset();
    step(1, 2'd1, 32'd9);
    step(1, 2'd0, 32'h1);
    for (int i = 1; i <= 6; i++) idle();
    step(1, 2'd0, 32'h0);
    check("ds_cnt7", r_rd[2], 32'd4);
    idle();
    check("ds_cnt8", r_rd[2], 32'd4);
    idle();
    check("ds_cnt9", r_rd[2], 32'd4);
    step(1, 2'd0, 32'h1);
    idle();
    check("ds_re1", r_rd[2], 32'd4);
    idle();
    check("ds_re2", r_rd[2], 32'd9);

    // Reset mid-count at COUNT=7.
    do_reset();
    step(1, 2'd1, 32'd12);
    step(1, 2'd0, 32'h9);
    for (int i = 1; i <= 7; i++) idle();
    check("rm_cnt7", r_rd[2], 32'd7);
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      idle();
      check($sformatf("rm_irq%0d", i), {31'd0, r_irq}, 32'd0);
    end
    check("rm_cnt", r_rd[2], 32'd0);

`ifdef TC_PRESCALE_EN
    // Prescale P=3, PRESET=2.
    do_reset();
    step(1, 2'd1, 32'd2);
    step(1, 2'd0, 32'h39);
    for (int i = 1; i <= 12; i++) begin
      idle();
      if (i == 2) check("ps_cnt2", r_rd[2], 32'd2);
      if (i >= 3 && i <= 6) check($sformatf("ps_cnt%0d", i), r_rd[2], 32'd1);
      if (i >= 7 && i <= 10) check($sformatf("ps_cnt%0d", i), r_rd[2], 32'd0);
      check($sformatf("ps_irq%0d", i), {31'd0, r_irq}, {31'd0, (i >= 11) ? 1'b1 : 1'b0});
    end
    p_sel = 8'($urandom_range(0, 3));
`else
    p_sel = 8'd0;
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 7) begin
`ifdef TC_PRESCALE_EN
        d[11:4] = p_sel;
`endif
        step(1, 2'd0, d);
      end else if (r < 11) begin
        step(1, 2'd1, 32'($urandom_range(0, 6)));
      end else if (r < 14) begin
        step(1, 2'($urandom_range(2, 3)), d);
      end else if (r < 15) begin
        do_reset();
      end else begin
        step(0, 2'($urandom_range(0, 3)), d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
